// File: rtl/tracer_stream.sv
// tracer_stream: DDA raycasting column tracer. Emits one height/side/wall record
// per screen column over a valid/ready stream, with clear records outside the traced span.
module tracer_stream #(
    parameter int COLS        = 640,
    parameter int TRACE_START = 64,
    parameter int INC_SHIFT   = 8,
    parameter int MAP_BITS    = 4,
    parameter int MAX_STEPS   = 32,
    parameter int HEIGHT_MAX  = 240,
    parameter int HEIGHT_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic signed [15:0]       playerX,
    input  logic signed [15:0]       playerY,
    input  logic signed [15:0]       facingX,
    input  logic signed [15:0]       facingY,
    input  logic signed [15:0]       vplaneX,
    input  logic signed [15:0]       vplaneY,
    output logic [MAP_BITS-1:0]      map_col,
    output logic [MAP_BITS-1:0]      map_row,
    input  logic [1:0]               map_val,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(COLS)-1:0]  out_column,
    output logic                     out_side,
    output logic [HEIGHT_BITS-1:0]   out_height,
    output logic [1:0]               out_wall,
    output logic                     busy,
    output logic                     frame_done
);

    localparam int CW          = $clog2(COLS);
    localparam int SW          = $clog2(MAX_STEPS + 1);
    localparam int LAST_TRACED = TRACE_START + (2 << INC_SHIFT) - 1;
    localparam logic [MAP_BITS-1:0] MAP_MAX = {MAP_BITS{1'b1}};
    localparam logic [MAP_BITS-1:0] MAP_MIN = {MAP_BITS{1'b0}};

    typedef enum logic [2:0] {IDLE, LCLEAR, INIT, STEP, CHECK, EMIT, RCLEAR, DONE} state_t;

    // Magnitude of a signed Q6.10 value, widened so -32768 is representable.
    function automatic logic [16:0] absVal(input logic signed [15:0] v);
        absVal = v[15] ? (17'd0 - {v[15], v}) : {1'b0, v};
    endfunction

    // |1/x| in Q6.10; bit 16 flags saturation (zero or too small a divisor).
    function automatic logic [16:0] recipAbs(input logic [16:0] mag);
        logic [31:0] q;
        q = 32'd0;
        if (mag == 17'd0) begin
            recipAbs = {1'b1, 16'h7FFF};
        end else begin
            q = 32'h0010_0000 / {15'd0, mag};
            if (q > 32'd32767) begin
                recipAbs = {1'b1, 16'h7FFF};
            end else begin
                recipAbs = {1'b0, q[15:0]};
            end
        end
    endfunction

    function automatic logic [10:0] partialOf(input logic [9:0] frac, input logic signed [15:0] dir);
        partialOf = (dir > 16'sd0) ? (11'd1024 - {1'b0, frac}) : {1'b0, frac};
    endfunction

    function automatic logic [15:0] trackStart(input logic [15:0] step, input logic [10:0] part);
        logic [31:0] prod;
        prod = {16'd0, step} * {21'd0, part};
        trackStart = prod[25:10];
    endfunction

    function automatic logic [15:0] satAdd(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        satAdd = s[16] ? 16'hFFFF : s[15:0];
    endfunction

    state_t                   state_r;
    logic [CW-1:0]            col_r;
    logic signed [15:0]       posX_r, posY_r;
    logic signed [15:0]       rayDirX_r, rayDirY_r, rayIncX_r, rayIncY_r;
    logic [MAP_BITS-1:0]      mapX_r, mapY_r;
    logic [15:0]              stepX_r, stepY_r, trackX_r, trackY_r;
    logic                     stopX_r, stopY_r, side_r, hit_r;
    logic [SW-1:0]            stepCnt_r;
    logic [1:0]               wall_r;
    logic                     outValid_r, outSide_r, busy_r, frameDone_r;
    logic [CW-1:0]            outColumn_r;
    logic [HEIGHT_BITS-1:0]   outHeight_r;
    logic [1:0]               outWall_r;

    logic [16:0]              recipX_s, recipY_s, scale_s;
    logic                     posDirX_s, posDirY_s, chooseX_s, leave_s;
    logic [15:0]              dist_s;
    logic [31:0]              heightProd_s;
    logic [HEIGHT_BITS-1:0]   height_s;
    logic                     unusedPosBits_s;

    assign map_col    = mapX_r;
    assign map_row    = mapY_r;
    assign out_valid  = outValid_r;
    assign out_column = outColumn_r;
    assign out_side   = outSide_r;
    assign out_height = outHeight_r;
    assign out_wall   = outWall_r;
    assign busy       = busy_r;
    assign frame_done = frameDone_r;
    assign unusedPosBits_s = ^{posX_r[15:MAP_BITS+10], posY_r[15:MAP_BITS+10]};

    // Step reciprocals, DDA step choice, edge detection and wall height.
    always_comb begin
        recipX_s  = recipAbs(absVal(rayDirX_r));
        recipY_s  = recipAbs(absVal(rayDirY_r));
        posDirX_s = (rayDirX_r > 16'sd0);
        posDirY_s = (rayDirY_r > 16'sd0);
        chooseX_s = stopY_r || (!stopX_r && (trackX_r < trackY_r));
        if (chooseX_s) begin
            leave_s = posDirX_s ? (mapX_r == MAP_MAX) : (mapX_r == MAP_MIN);
        end else begin
            leave_s = posDirY_s ? (mapY_r == MAP_MAX) : (mapY_r == MAP_MIN);
        end
        dist_s       = side_r ? (trackY_r - stepY_r) : (trackX_r - stepX_r);
        scale_s      = recipAbs({1'b0, dist_s});
        heightProd_s = 32'(HEIGHT_MAX) * {16'd0, scale_s[15:0]};
        if (scale_s[16] || (scale_s[15:0] > 16'd1024)) begin
            height_s = HEIGHT_BITS'(HEIGHT_MAX);
        end else if (heightProd_s[31:10] == 22'd0) begin
            height_s = HEIGHT_BITS'(1);
        end else begin
            height_s = heightProd_s[10 +: HEIGHT_BITS];
        end
    end

    // Frame sequencer: clears, per-column DDA walk and stream handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            col_r       <= {CW{1'b0}};
            posX_r      <= 16'sd0;
            posY_r      <= 16'sd0;
            rayDirX_r   <= 16'sd0;
            rayDirY_r   <= 16'sd0;
            rayIncX_r   <= 16'sd0;
            rayIncY_r   <= 16'sd0;
            mapX_r      <= MAP_MIN;
            mapY_r      <= MAP_MIN;
            stepX_r     <= 16'd0;
            stepY_r     <= 16'd0;
            trackX_r    <= 16'd0;
            trackY_r    <= 16'd0;
            stopX_r     <= 1'b0;
            stopY_r     <= 1'b0;
            side_r      <= 1'b0;
            hit_r       <= 1'b0;
            stepCnt_r   <= {SW{1'b0}};
            wall_r      <= 2'd0;
            outValid_r  <= 1'b0;
            outColumn_r <= {CW{1'b0}};
            outSide_r   <= 1'b0;
            outHeight_r <= {HEIGHT_BITS{1'b0}};
            outWall_r   <= 2'd0;
            busy_r      <= 1'b0;
            frameDone_r <= 1'b0;
        end else begin
            frameDone_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        posX_r    <= playerX;
                        posY_r    <= playerY;
                        rayDirX_r <= facingX - vplaneX;
                        rayDirY_r <= facingY - vplaneY;
                        rayIncX_r <= vplaneX >>> INC_SHIFT;
                        rayIncY_r <= vplaneY >>> INC_SHIFT;
                        col_r     <= {CW{1'b0}};
                        busy_r    <= 1'b1;
                        state_r   <= (TRACE_START > 0) ? LCLEAR : INIT;
                    end
                end
                LCLEAR, RCLEAR: begin
                    if (!outValid_r) begin
                        outValid_r  <= 1'b1;
                        outColumn_r <= col_r;
                        outSide_r   <= 1'b0;
                        outHeight_r <= {HEIGHT_BITS{1'b0}};
                        outWall_r   <= 2'd0;
                    end else if (out_ready) begin
                        if ((state_r == LCLEAR) && (col_r == CW'(TRACE_START - 1))) begin
                            outValid_r <= 1'b0;
                            col_r      <= col_r + CW'(1);
                            state_r    <= INIT;
                        end else if ((state_r == RCLEAR) && (col_r == CW'(COLS - 1))) begin
                            outValid_r  <= 1'b0;
                            frameDone_r <= 1'b1;
                            busy_r      <= 1'b0;
                            state_r     <= DONE;
                        end else begin
                            col_r       <= col_r + CW'(1);
                            outColumn_r <= col_r + CW'(1);
                        end
                    end
                end
                INIT: begin
                    mapX_r    <= posX_r[10 +: MAP_BITS];
                    mapY_r    <= posY_r[10 +: MAP_BITS];
                    stepX_r   <= recipX_s[15:0];
                    stepY_r   <= recipY_s[15:0];
                    stopX_r   <= recipX_s[16] | recipX_s[14];
                    stopY_r   <= recipY_s[16] | recipY_s[14];
                    trackX_r  <= trackStart(recipX_s[15:0], partialOf(posX_r[9:0], rayDirX_r));
                    trackY_r  <= trackStart(recipY_s[15:0], partialOf(posY_r[9:0], rayDirY_r));
                    stepCnt_r <= {SW{1'b0}};
                    side_r    <= 1'b0;
                    hit_r     <= 1'b0;
                    state_r   <= STEP;
                end
                STEP: begin
                    // Leaving the map or running out of steps ends the ray as a miss.
                    if (leave_s || (stepCnt_r == SW'(MAX_STEPS))) begin
                        hit_r   <= 1'b0;
                        state_r <= EMIT;
                    end else begin
                        stepCnt_r <= stepCnt_r + SW'(1);
                        if (chooseX_s) begin
                            mapX_r   <= posDirX_s ? (mapX_r + MAP_BITS'(1)) : (mapX_r - MAP_BITS'(1));
                            trackX_r <= satAdd(trackX_r, stepX_r);
                            side_r   <= 1'b0;
                        end else begin
                            mapY_r   <= posDirY_s ? (mapY_r + MAP_BITS'(1)) : (mapY_r - MAP_BITS'(1));
                            trackY_r <= satAdd(trackY_r, stepY_r);
                            side_r   <= 1'b1;
                        end
                        state_r <= CHECK;
                    end
                end
                CHECK: begin
                    if (map_val != 2'd0) begin
                        hit_r   <= 1'b1;
                        wall_r  <= map_val;
                        state_r <= EMIT;
                    end else begin
                        state_r <= STEP;
                    end
                end
                EMIT: begin
                    if (!outValid_r) begin
                        outValid_r  <= 1'b1;
                        outColumn_r <= col_r;
                        outSide_r   <= side_r;
                        outHeight_r <= hit_r ? height_s : {HEIGHT_BITS{1'b0}};
                        outWall_r   <= hit_r ? wall_r : 2'd0;
                    end else if (out_ready) begin
                        outValid_r <= 1'b0;
                        if (col_r == CW'(LAST_TRACED)) begin
                            if (col_r == CW'(COLS - 1)) begin
                                frameDone_r <= 1'b1;
                                busy_r      <= 1'b0;
                                state_r     <= DONE;
                            end else begin
                                col_r   <= col_r + CW'(1);
                                state_r <= RCLEAR;
                            end
                        end else begin
                            col_r     <= col_r + CW'(1);
                            rayDirX_r <= rayDirX_r + rayIncX_r;
                            rayDirY_r <= rayDirY_r + rayIncY_r;
                            state_r   <= INIT;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tracer_stream.sv
// Directed bench for tracer_stream: border/empty maps, backpressure, reset mid-frame
// and ignored start pulses, checked against hand-computed values.
`timescale 1ns/1ps
module tb_tracer_stream;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic signed [15:0] playerX = 16'sd0, playerY = 16'sd0;
    logic signed [15:0] facingX = 16'sd0, facingY = 16'sd0;
    logic signed [15:0] vplaneX = 16'sd0, vplaneY = 16'sd0;
    logic [3:0]         map_col, map_row;
    logic [1:0]         map_val;
    logic               out_valid, out_ready = 1'b1;
    logic [9:0]         out_column;
    logic               out_side;
    logic [7:0]         out_height;
    logic [1:0]         out_wall;
    logic               busy, frame_done;

    logic [1:0] mapMem [0:15][0:15];
    assign map_val = mapMem[map_row][map_col];

    tracer_stream dut (
        .clk(clk), .reset(reset), .start(start),
        .playerX(playerX), .playerY(playerY),
        .facingX(facingX), .facingY(facingY),
        .vplaneX(vplaneX), .vplaneY(vplaneY),
        .map_col(map_col), .map_row(map_row), .map_val(map_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_column(out_column), .out_side(out_side),
        .out_height(out_height), .out_wall(out_wall),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass = 0;
    int cycle = 0;
    int fdCnt = 0, stallErr = 0, stall100 = 0;
    int recCol[$], recH[$], recSide[$], recWall[$], recCyc[$];
    logic       pValid = 1'b0, pReady = 1'b0, pSide = 1'b0;
    logic [9:0] pCol = 10'd0;
    logic [7:0] pH = 8'd0;
    logic [1:0] pWall = 2'd0;

    task automatic chk(input string tag, input int obs, input int exp);
        nChecks++;
        if (obs == exp) nPass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // Stream monitor: logs accepted records and checks stalled records stay put.
    always @(negedge clk) begin
        if (reset) begin
            pValid <= 1'b0;
        end else begin
            if (pValid && !pReady &&
                (!out_valid || out_column != pCol || out_side != pSide ||
                 out_height != pH || out_wall != pWall))
                stallErr <= stallErr + 1;
            if (out_valid && !out_ready && out_column == 10'd100) stall100 <= stall100 + 1;
            if (out_valid && out_ready) begin
                recCol.push_back(int'(out_column));
                recH.push_back(int'(out_height));
                recSide.push_back(int'(out_side));
                recWall.push_back(int'(out_wall));
                recCyc.push_back(cycle);
            end
            if (frame_done) fdCnt <= fdCnt + 1;
            pValid <= out_valid; pReady <= out_ready; pCol <= out_column;
            pSide <= out_side; pH <= out_height; pWall <= out_wall;
        end
    end

    task automatic setMap(input bit border);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                mapMem[r][c] = (border && (r == 0 || r == 15 || c == 0 || c == 15)) ? 2'd1 : 2'd0;
    endtask

    task automatic startFrame(input string tag);
        chk({tag, "_busy_pre"}, busy, 0);
        out_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy_rise"}, busy, 1);
    endtask

    // Runs until frame_done; mode 1 stalls column 100 for 10 cycles then randomises ready.
    task automatic runFrame(input int mode, input bit pulses, output int timedOut);
        int fd0, phase, held;
        fd0 = fdCnt; phase = 0; held = 0; timedOut = 1;
        for (int t = 0; t < 30000; t++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (fdCnt != fd0) begin
                timedOut = 0;
                break;
            end
            if (mode == 1) begin
                if (phase == 0) begin
                    if (out_valid && out_column == 10'd100) begin
                        out_ready = 1'b0; phase = 1; held = 1;
                    end
                end else if (phase == 1) begin
                    if (held < 10) held++;
                    else phase = 2;
                end
                if (phase == 2) out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
            if (pulses && (t % 1500 == 700)) start = 1'b1;
        end
        out_ready = 1'b1;
    endtask

    task automatic frameStats(input int base, input int expWall,
                              output int n, output int orderErr, output int clearErr, output int tracedErr);
        n = recCol.size() - base;
        orderErr = 0; clearErr = 0; tracedErr = 0;
        for (int i = 0; i < n; i++) begin
            if (recCol[base+i] != i) orderErr++;
            if (i < 64 || i > 575) begin
                if (recH[base+i] != 0 || recWall[base+i] != 0 || recSide[base+i] != 0) clearErr++;
            end else if (expWall == 0) begin
                if (recH[base+i] != 0 || recWall[base+i] != 0) tracedErr++;
            end else begin
                if (recH[base+i] == 0 || recWall[base+i] != expWall) tracedErr++;
            end
        end
    endtask

    function automatic int recAt(input int q[$], input int base, input int c);
        if (base + c < q.size()) return q[base+c];
        return -1;
    endfunction

    int base1, base, n, oe, ce, te, to, fd0, bad, maxGap, diff;

    initial begin
        setMap(1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_column", out_column, 0);
        chk("rst_height", out_height, 0);
        chk("rst_wall", out_wall, 0);
        chk("rst_map", {map_row, map_col}, 0);
        reset = 1'b0;
        bad = 0;
        repeat (1000) begin
            @(posedge clk); #1;
            if (out_valid || busy || frame_done) bad++;
        end
        chk("idle1000", bad, 0);

        // Border map, player (8.5,8.5), facing (1,0), vplane (0,0.5)
        playerX = 16'sd8704; playerY = 16'sd8704;
        facingX = 16'sd1024; facingY = 16'sd0;
        vplaneX = 16'sd0;    vplaneY = 16'sd512;
        base1 = recCol.size(); fd0 = fdCnt;
        startFrame("f1");
        runFrame(0, 1'b0, to);
        chk("f1_timeout", to, 0);
        chk("f1_busy_end", busy, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("f1_done_pulses", fdCnt - fd0, 1);
        frameStats(base1, 1, n, oe, ce, te);
        chk("f1_records", n, 640);
        chk("f1_order", oe, 0);
        chk("f1_clears", ce, 0);
        chk("f1_traced_wall", te, 0);
        chk("f1_c320_side", recAt(recSide, base1, 320), 0);
        chk("f1_c320_wall", recAt(recWall, base1, 320), 1);
        chk("f1_c320_height", recAt(recH, base1, 320), 36);

        // Same frame with a 10-cycle stall on column 100, then random ready
        base = recCol.size(); fd0 = fdCnt;
        startFrame("f2");
        runFrame(1, 1'b0, to);
        chk("f2_timeout", to, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("f2_done_pulses", fdCnt - fd0, 1);
        chk("f2_stall_stable", stallErr, 0);
        chk("f2_stall_held", (stall100 >= 10) ? 1 : 0, 1);
        frameStats(base, 1, n, oe, ce, te);
        chk("f2_records", n, 640);
        chk("f2_order", oe, 0);
        diff = 0;
        for (int i = 0; i < 640; i++)
            if (recAt(recH, base, i) != recAt(recH, base1, i)) diff++;
        chk("f2_same_heights", diff, 0);

        // Empty map, vplane (0,0): X-only walk to the map edge
        setMap(1'b0);
        vplaneY = 16'sd0;
        base = recCol.size();
        startFrame("f3");
        runFrame(0, 1'b0, to);
        chk("f3_timeout", to, 0);
        frameStats(base, 0, n, oe, ce, te);
        chk("f3_records", n, 640);
        chk("f3_traced_miss", te, 0);
        maxGap = 0;
        for (int c = 65; c < 576 && c < n; c++)
            if (recCyc[base+c] - recCyc[base+c-1] > maxGap) maxGap = recCyc[base+c] - recCyc[base+c-1];
        chk("f3_gap_le19", (maxGap <= 19 && maxGap > 0) ? 1 : 0, 1);

        // Reset while column 300 is presented, then restart
        setMap(1'b1);
        vplaneY = 16'sd512;
        startFrame("f4");
        to = 1;
        for (int t = 0; t < 20000; t++) begin
            @(posedge clk); #1;
            if (out_valid && out_column == 10'd300) begin
                to = 0;
                break;
            end
        end
        chk("f4_reach300", to, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("f4_rst_valid", out_valid, 0);
        chk("f4_rst_busy", busy, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        base = recCol.size();
        startFrame("f4r");
        for (int t = 0; t < 300 && (recCol.size() - base) < 64; t++) begin
            @(posedge clk); #1;
        end
        frameStats(base, 1, n, oe, ce, te);
        chk("f4r_clear_count", (n >= 64) ? 1 : 0, 1);
        chk("f4r_order", oe, 0);
        chk("f4r_clears", ce, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Wall at distance 0.25 with start pulses during the frame
        playerX = 16'sd15104;
        base = recCol.size(); fd0 = fdCnt;
        startFrame("f5");
        runFrame(0, 1'b1, to);
        chk("f5_timeout", to, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("f5_done_pulses", fdCnt - fd0, 1);
        chk("f5_busy_end", busy, 0);
        frameStats(base, 1, n, oe, ce, te);
        chk("f5_records", n, 640);
        chk("f5_order", oe, 0);
        chk("f5_c320_height", recAt(recH, base, 320), 240);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
